counter_cmd_seq: RTL and testbench

//   Command sequencer that sits directly upstream of the 4-bit load/up-down counter.
//   - Accepts LOAD / UP / DOWN / NOP commands over a valid/ready port into a small FIFO.
//   - Replays each command as cycle-accurate load/data/up_d (+ step_en) strobes to the counter.
//   - Lets software-style stimulus ("load 2, count up 5, count down 3") run back-to-back

---
 rtl/counter_cmd_seq.sv | 206 ++++++++++++++++++++
 tb/tb_counter_cmd_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_cmd_seq.sv
// Command sequencer feeding a load/up-down counter.
// Commands (NOP/LOAD/UP/DOWN) are queued in a small FIFO and replayed as
// cycle-accurate load/data/up_d/step_en strobes with zero gap between commands.
module counter_cmd_seq #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 4,
    parameter  int LEN_W = 8,
    localparam int LVL_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             flush,
    output logic             load,
    output logic [WIDTH-1:0] data,
    output logic             up_d,
    output logic             step_en,
    output logic             done,
    output logic             busy,
    output logic [LVL_W-1:0] level
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    // FIFO storage and pointers
    logic [1:0]       r_op_mem  [DEPTH];
    logic [WIDTH-1:0] r_arg_mem [DEPTH];
    logic [LEN_W-1:0] r_len_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    // FSM and registered outputs
    state_t           r_state;
    logic [LEN_W-1:0] r_rem;
    logic             r_load;
    logic [WIDTH-1:0] r_data;
    logic             r_up_d;
    logic             r_step_en;
    logic             r_done;
    logic             r_busy;

    // Next-state values
    state_t           w_state_nxt;
    logic [LEN_W-1:0] w_rem_nxt;
    logic             w_load_nxt;
    logic [WIDTH-1:0] w_data_nxt;
    logic             w_up_nxt;
    logic             w_step_nxt;
    logic             w_done_nxt;
    logic [LVL_W-1:0] w_level_nxt;
    logic             w_busy_nxt;

    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_head_op;
    logic [WIDTH-1:0] w_head_arg;
    logic [LEN_W-1:0] w_head_len;

    // Space is judged on the current level only, so a same-cycle pop never frees room
    assign w_full     = (r_level == LVL_W'(DEPTH));
    assign w_push     = cmd_valid && !w_full && !flush && !reset;
    assign w_pop      = ((r_state == S_IDLE) || r_done) && (r_level != {LVL_W{1'b0}});
    assign w_head_op  = r_op_mem[r_rd_ptr];
    assign w_head_arg = r_arg_mem[r_rd_ptr];
    assign w_head_len = r_len_mem[r_rd_ptr];

    assign cmd_ready = !w_full;
    assign load      = r_load;
    assign data      = r_data;
    assign up_d      = r_up_d;
    assign step_en   = r_step_en;
    assign done      = r_done;
    assign busy      = r_busy;
    assign level     = r_level;

    // Command storage write (contents need no reset; occupancy is tracked by pointers)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op_mem[r_wr_ptr]  <= cmd_op;
            r_arg_mem[r_wr_ptr] <= cmd_arg;
            r_len_mem[r_wr_ptr] <= cmd_len;
        end
    end

    // Next-state and next-output decode: pop/launch a command, keep running, or go idle
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_load_nxt  = 1'b0;
        w_data_nxt  = r_data;
        w_up_nxt    = r_up_d;
        w_step_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_rem_nxt   = {LEN_W{1'b0}};
            w_data_nxt  = {WIDTH{1'b0}};
            w_up_nxt    = 1'b0;
        end else if (w_pop) begin
            case (w_head_op)
                OP_LOAD: begin
                    w_state_nxt = S_EXEC;
                    w_load_nxt  = 1'b1;
                    w_data_nxt  = w_head_arg;
                    w_done_nxt  = 1'b1;
                end
                OP_UP, OP_DOWN: begin
                    w_up_nxt = (w_head_op == OP_UP);
                    if (w_head_len == {LEN_W{1'b0}}) begin
                        w_state_nxt = S_EXEC;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_rem_nxt   = w_head_len;
                        w_step_nxt  = 1'b1;
                        w_done_nxt  = (w_head_len == LEN_W'(1));
                    end
                end
                OP_NOP: begin
                    w_state_nxt = S_EXEC;
                    w_done_nxt  = 1'b1;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end else if ((r_state == S_RUN) && !r_done) begin
            // r_rem counts steps left including the current one
            w_state_nxt = S_RUN;
            w_rem_nxt   = r_rem - LEN_W'(1);
            w_step_nxt  = 1'b1;
            w_done_nxt  = (r_rem == LEN_W'(2));
        end else begin
            w_state_nxt = S_IDLE;
            w_rem_nxt   = {LEN_W{1'b0}};
        end
    end

    // FIFO occupancy next value
    always_comb begin
        w_level_nxt = r_level;
        if (flush) begin
            w_level_nxt = {LVL_W{1'b0}};
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_level_nxt = r_level + LVL_W'(1);
                2'b01:   w_level_nxt = r_level - LVL_W'(1);
                default: w_level_nxt = r_level;
            endcase
        end
        w_busy_nxt = (w_state_nxt != S_IDLE) || (w_level_nxt != {LVL_W{1'b0}});
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_level  <= {LVL_W{1'b0}};
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_level <= w_level_nxt;
        end
    end

    // FSM state and registered output strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rem     <= {LEN_W{1'b0}};
            r_load    <= 1'b0;
            r_data    <= {WIDTH{1'b0}};
            r_up_d    <= 1'b0;
            r_step_en <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rem     <= w_rem_nxt;
            r_load    <= w_load_nxt;
            r_data    <= w_data_nxt;
            r_up_d    <= w_up_nxt;
            r_step_en <= w_step_nxt;
            r_done    <= w_done_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Self-checking bench for counter_cmd_seq: directed scenarios plus random
// stimulus, compared every cycle against a queue-based transaction model.
module tb_counter_cmd_seq;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int LEN_W = 8;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;
    logic [LEN_W-1:0] cmd_len;
    logic             flush;
    logic             load;
    logic [WIDTH-1:0] data;
    logic             up_d;
    logic             step_en;
    logic             done;
    logic             busy;
    logic [LVL_W-1:0] level;

    int n_checks = 0;
    int n_errors = 0;

    counter_cmd_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_len(cmd_len), .flush(flush),
        .load(load), .data(data), .up_d(up_d), .step_en(step_en), .done(done),
        .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    // Reference model: queued commands, and per-cycle output records
    // {load, step_en, done} of the command currently being replayed.
    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] arg;
        logic [LEN_W-1:0] len;
    } cmd_t;

    cmd_t             cmdq[$];
    logic [2:0]       oq[$];
    logic [WIDTH-1:0] m_data;
    logic             m_up;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [2:0] r;
        r = (oq.size() > 0) ? oq[0] : 3'b000;
        chk("load",      32'(load),      32'(r[2]));
        chk("step_en",   32'(step_en),   32'(r[1]));
        chk("done",      32'(done),      32'(r[0]));
        chk("data",      32'(data),      32'(m_data));
        chk("up_d",      32'(up_d),      32'(m_up));
        chk("level",     32'(level),     32'(cmdq.size()));
        chk("busy",      32'(busy),      32'((oq.size() != 0) || (cmdq.size() != 0)));
        chk("cmd_ready", 32'(cmd_ready), 32'(cmdq.size() != DEPTH));
    endtask

    task automatic model_edge(input logic v, input cmd_t c, input logic fl, input logic rs,
                              output logic acc);
        logic was_idle, was_done;
        cmd_t h;
        acc = 1'b0;
        if (rs || fl) begin
            cmdq.delete();
            oq.delete();
            m_data = '0;
            m_up   = 1'b0;
        end else begin
            acc      = v && (cmdq.size() < DEPTH);
            was_idle = (oq.size() == 0);
            was_done = !was_idle && oq[0][0];
            if (!was_idle) void'(oq.pop_front());
            if ((was_idle || was_done) && cmdq.size() > 0) begin
                h = cmdq.pop_front();
                case (h.op)
                    2'd1: begin oq.push_back(3'b101); m_data = h.arg; end
                    2'd0: oq.push_back(3'b001);
                    default: begin
                        m_up = (h.op == 2'd2);
                        if (h.len == 0) oq.push_back(3'b001);
                        else for (int i = 0; i < int'(h.len); i++)
                            oq.push_back({1'b0, 1'b1, (i == int'(h.len) - 1)});
                    end
                endcase
            end
            if (acc) cmdq.push_back(c);
        end
    endtask

    // One clock: check current outputs, drive inputs, advance DUT and model.
    task automatic cycle(input logic v, input logic [1:0] op, input logic [WIDTH-1:0] arg,
                         input logic [LEN_W-1:0] len, input logic fl, input logic rs,
                         output logic acc);
        cmd_t c;
        check_outputs();
        cmd_valid = v; cmd_op = op; cmd_arg = arg; cmd_len = len;
        flush = fl; reset = rs;
        c.op = op; c.arg = arg; c.len = len;
        @(posedge clk);
        model_edge(v, c, fl, rs, acc);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, '0, '0, 1'b0, 1'b0, a);
    endtask

    task automatic push(input logic [1:0] op, input logic [WIDTH-1:0] arg, input logic [LEN_W-1:0] len);
        logic a;
        cycle(1'b1, op, arg, len, 1'b0, 1'b0, a);
        chk("push_accepted", 32'(a), 32'd1);
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((oq.size() != 0 || cmdq.size() != 0) && n < max_cycles) begin
            idle(1);
            n++;
        end
        chk("drain_timeout", 32'(oq.size() + cmdq.size()), 32'd0);
    endtask

    initial begin
        logic a;
        int   cnt;
        int   n;
        cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0; cmd_len = '0; flush = 1'b0;
        reset = 1'b1;
        m_data = '0; m_up = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        // 1. reset state against fixed values
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_strobes", 32'({load, step_en, done, up_d, data}), 32'd0);
        reset = 1'b0;

        // 2. LOAD 2 then UP 5
        push(2'd1, 4'd2, 8'd0);
        push(2'd2, 4'd0, 8'd5);
        drain(50);
        idle(2);
        chk("t2_final_data", 32'(data), 32'd2);

        // 3. UP 20 then NOPs held valid until five are accepted
        push(2'd2, 4'd0, 8'd20);
        cnt = 0; n = 0;
        while (cnt < 5 && n < 200) begin
            cycle(1'b1, 2'd0, '0, '0, 1'b0, 1'b0, a);
            if (a) cnt++;
            n++;
        end
        chk("t3_nops_accepted", 32'(cnt), 32'd5);
        drain(100);

        // 4. back-to-back UP 3, DOWN 2; 5. DOWN 0
        push(2'd2, 4'd0, 8'd3);
        push(2'd3, 4'd0, 8'd2);
        drain(50);
        push(2'd3, 4'd0, 8'd0);
        drain(20);

        // 6. flush, then reset, on step 4 of UP 10 with two commands queued
        for (int k = 0; k < 2; k++) begin
            push(2'd2, 4'd0, 8'd10);
            push(2'd1, 4'd7, 8'd0);
            push(2'd0, 4'd0, 8'd0);
            n = 0;
            while (oq.size() != 7 && n < 50) begin idle(1); n++; end
            chk("t6_reached_step4", 32'(oq.size()), 32'd7);
            cycle(1'b1, 2'd1, 4'd9, '0, (k == 0), (k == 1), a);
            chk("t6_step_en", 32'(step_en), 32'd0);
            chk("t6_level",   32'(level),   32'd0);
            chk("t6_busy",    32'(busy),    32'd0);
            idle(5);
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [LEN_W-1:0] len;
            len = ($urandom % 8 == 0) ? LEN_W'($urandom % 40) : LEN_W'($urandom % 5);
            cycle(1'($urandom % 2), 2'($urandom), 4'($urandom), len,
                  ($urandom % 64 == 0), ($urandom % 300 == 0), a);
        end
        drain(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
